// File: rtl/sparse_hls_dl_confirm_unit.sv
// Per-process deadlock confirm unit: merges dependences, filters self-dependence persistence, reports via valid/ready.
// Optional saturating stall counter port enabled by SPARSE_HLS_DL_STALL_CNT_EN.
module sparse_hls_dl_confirm_unit #(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int CONFIRM_CYCLES = 4,
  parameter int CNT_W          = $clog2(CONFIRM_CYCLES + 1)
) (
  input  logic                            reset,
  input  logic                            clock,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  input  logic                            report_ready,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic                            report_valid,
  output logic [PROC_NUM-1:0]             report_dep
`ifdef SPARSE_HLS_DL_STALL_CNT_EN
  ,
  output logic [15:0]                     stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, TRACK, CONFIRM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_CYCLES);
  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [PROC_NUM-1:0] dep_comb, dep, dep_reg;
  logic                sel, blocked, hit, capture;

  always_comb begin
    dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (in_chan_dep_vld_vec[i]) begin
        dep_comb = dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      end
    end
  end

  // Once another unit has flagged deadlock, only a token holder refreshes its view.
  assign sel     = ~dl_detect_in | (|token_in_vec);
  assign dep     = sel ? dep_comb : dep_reg;
  assign blocked = |proc_dep_vld_vec;
  assign hit     = sel & dep[PROC_ID] & blocked;

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = dep_reg | SELF_BIT;
  assign report_valid         = (state == CONFIRM);
  assign dl_detect_out        = (state == CONFIRM) || (state == HOLD);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          cnt_next = CNT_W'(1);
          if (CONFIRM_CYCLES == 1) begin
            state_next = CONFIRM;
            capture    = 1'b1;
          end else begin
            state_next = TRACK;
          end
        end
      end
      TRACK: begin
        if (hit) begin
          if (cnt == CNT_MAX - CNT_W'(1)) begin
            state_next = CONFIRM;
            cnt_next   = CNT_MAX;
            capture    = 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_W'(1);
          end
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      CONFIRM: begin
        if (report_ready) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!hit || token_clear) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dep_reg    <= '0;
      report_dep <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      dep_reg <= blocked ? dep : '0;
      if (capture) begin
        report_dep <= dep;
      end
    end
  end

  // origin forwards the token even when token_clear is asserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      token_out_vec <= '0;
    end else if (((|token_in_vec) & ~token_clear) | origin) begin
      token_out_vec <= proc_dep_vld_vec;
    end else begin
      token_out_vec <= '0;
    end
  end

`ifdef SPARSE_HLS_DL_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (report_valid) begin
      stall_cycles <= stall_cycles;
    end else if (blocked) begin
      if (stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end else begin
      stall_cycles <= '0;
    end
  end
`endif

endmodule
